// File: rtl/ac_cmd_encoder_pkg.sv
// ac_ir_pkg: shared definitions for the AC remote command encoder.
//   - AC mode encodings, temperature code limits and reset values
//   - IR frame field bit positions
//   - default frame constants (TAIL35 / HEAD32)
//   - frame builders and frame checksum helper
//   - publish FSM state type
package ac_ir_pkg;

  localparam logic [2:0] MODE_AUTO = 3'd0;
  localparam logic [2:0] MODE_COOL = 3'd1;
  localparam logic [2:0] MODE_DRY  = 3'd2;
  localparam logic [2:0] MODE_FAN  = 3'd3;
  localparam logic [2:0] MODE_HEAT = 3'd4;

  localparam logic [3:0] TEMP_MIN  = 4'd0;   // 16 C
  localparam logic [3:0] TEMP_MAX  = 4'd14;  // 30 C
  localparam logic [3:0] TEMP_RST  = 4'd10;  // 26 C
  localparam logic [1:0] FAN_RST   = 2'd0;

  localparam int NUM_BTN  = 5;
  localparam int BTN_PWR  = 0;
  localparam int BTN_MODE = 1;
  localparam int BTN_FAN  = 2;
  localparam int BTN_UP   = 3;
  localparam int BTN_DN   = 4;

  localparam int D35_W         = 35;
  localparam int D32_W         = 32;
  localparam int D35_MODE_LSB  = 32;
  localparam int D35_POWER_BIT = 31;
  localparam int D35_FAN_LSB   = 29;
  localparam int D35_TEMP_LSB  = 23;
  localparam int D32_HEAD_LSB  = 8;
  localparam int D32_SEQ_LSB   = 4;
  localparam int D32_CSUM_LSB  = 0;

  localparam logic [22:0] DEF_TAIL35 = 23'h000A52;
  localparam logic [23:0] DEF_HEAD32 = 24'h080400;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_PUBLISH = 2'd2
  } pub_state_t;

  // Sum is formed 5 bits wide and the low nibble is kept.
  function automatic logic [3:0] frame_checksum(input logic [2:0] mode,
                                                input logic [3:0] temp,
                                                input logic       power,
                                                input logic [1:0] fan);
    logic [4:0] sum;
    sum = 5'(mode) + 5'(temp) + 5'(power) + 5'(fan) + 5'd10;
    return sum[3:0];
  endfunction

  // Swing and sleep bits [28:27] are always zero.
  function automatic logic [D35_W-1:0] build_data35(input logic [2:0]  mode,
                                                    input logic        power,
                                                    input logic [1:0]  fan,
                                                    input logic [3:0]  temp,
                                                    input logic [22:0] tail);
    logic [D35_W-1:0] d;
    d = '0;
    d[D35_MODE_LSB +: 3] = mode;
    d[D35_POWER_BIT]     = power;
    d[D35_FAN_LSB +: 2]  = fan;
    d[D35_TEMP_LSB +: 4] = temp;
    d[22:0]              = tail;
    return d;
  endfunction

  function automatic logic [D32_W-1:0] build_data32(input logic [23:0] head,
                                                    input logic [3:0]  seq,
                                                    input logic [3:0]  csum);
    logic [D32_W-1:0] d;
    d = '0;
    d[D32_HEAD_LSB +: 24] = head;
    d[D32_SEQ_LSB +: 4]   = seq;
    d[D32_CSUM_LSB +: 4]  = csum;
    return d;
  endfunction

endpackage

// File: rtl/ac_cmd_encoder_if.sv
// ac_cmd_encoder_if: front-panel buttons in, IR frame words and status out.
//   btn_pwr/mode/fan/up/dn : raw active-high buttons (async to clk)
//   ir_data35, ir_data32   : frame words for the IR transmitter
//   frame_stb              : one-cycle pulse when both words update
//   power_on, temp_code    : LED / display status
// Modports: master = encoder side, slave = panel/transmitter side.
interface ac_cmd_encoder_if;
  import ac_ir_pkg::*;

  logic             btn_pwr;
  logic             btn_mode;
  logic             btn_fan;
  logic             btn_up;
  logic             btn_dn;
  logic [D35_W-1:0] ir_data35;
  logic [D32_W-1:0] ir_data32;
  logic             frame_stb;
  logic             power_on;
  logic [3:0]       temp_code;

  modport master (
    input  btn_pwr, btn_mode, btn_fan, btn_up, btn_dn,
    output ir_data35, ir_data32, frame_stb, power_on, temp_code
  );

  modport slave (
    output btn_pwr, btn_mode, btn_fan, btn_up, btn_dn,
    input  ir_data35, ir_data32, frame_stb, power_on, temp_code
  );

endinterface

// File: rtl/ac_cmd_encoder_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-level down-counter, press pulse.
//   clk, rst : clock, synchronous active-high reset
//   btn      : raw button, asynchronous to clk
//   press    : one-cycle pulse on an accepted 0->1 transition
// A new level is accepted only after it has differed from the accepted
// level for DEB_CYCLES consecutive cycles; any return resets the count.
module btn_debounce
  import ac_ir_pkg::*;
#(
  parameter int DEB_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic          lvl;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b00;
      lvl   <= 1'b0;
      cnt   <= RELOAD;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == lvl) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        lvl   <= sync[1];
        press <= sync[1];
        cnt   <= RELOAD;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/ac_cmd_encoder.sv
// ac_cmd_encoder: AC remote front-panel command encoder.
//   clk, rst : 125 MHz clock, synchronous active-high reset
//   bus      : ac_cmd_encoder_if.master (buttons in, frame words/status out)
// Holds power/mode/fan/temperature, and publishes a new frame pair with an
// incremented sequence number whenever the state changed, rate-limited so
// that consecutive publishes are at least TX_GAP cycles apart.
//
// Publish FSM
//   state      | meaning
//   IDLE       | no pending change, or waiting for one
//   HOLD       | change pending, waiting for gap_cnt to reach TX_GAP
//   PUBLISH    | strobe cycle; frame words were loaded on entry
module ac_cmd_encoder
  import ac_ir_pkg::*;
#(
  parameter int          DEB_CYCLES = 2_500_000,
  parameter int          TX_GAP     = 25_000_000,
  parameter logic [22:0] TAIL35     = DEF_TAIL35,
  parameter logic [23:0] HEAD32     = DEF_HEAD32
) (
  input logic              clk,
  input logic              rst,
  ac_cmd_encoder_if.master bus
);

  localparam int GW = $clog2(TX_GAP + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(TX_GAP);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  logic             power, power_n;
  logic [2:0]       mode, mode_n;
  logic [1:0]       fan, fan_n;
  logic [3:0]       temp, temp_n;
  logic [3:0]       seq;
  logic             dirty;
  logic             changed;
  logic [GW-1:0]    gap_cnt;
  logic             gap_full;
  pub_state_t       state, state_n;
  logic             load;
  logic [D35_W-1:0] ir35;
  logic [D32_W-1:0] ir32;
  logic             stb;

  assign btn_raw[BTN_PWR]  = bus.btn_pwr;
  assign btn_raw[BTN_MODE] = bus.btn_mode;
  assign btn_raw[BTN_FAN]  = bus.btn_fan;
  assign btn_raw[BTN_UP]   = bus.btn_up;
  assign btn_raw[BTN_DN]   = bus.btn_dn;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_raw[i]),
      .press (press[i])
    );
  end

  // Gating uses the pre-toggle power so a pwr press in the same cycle
  // neither enables nor blocks the other buttons.
  always_comb begin
    power_n = power;
    mode_n  = mode;
    fan_n   = fan;
    temp_n  = temp;
    if (press[BTN_PWR]) power_n = ~power;
    if (power) begin
      if (press[BTN_MODE]) mode_n = (mode == MODE_HEAT) ? MODE_AUTO : mode + 3'd1;
      if (press[BTN_FAN])  fan_n  = fan + 2'd1;
      if (press[BTN_UP] && !press[BTN_DN] && temp != TEMP_MAX) begin
        temp_n = temp + 4'd1;
      end else if (press[BTN_DN] && !press[BTN_UP] && temp != TEMP_MIN) begin
        temp_n = temp - 4'd1;
      end
    end
    changed = (power_n != power) || (mode_n != mode) ||
              (fan_n != fan) || (temp_n != temp);
  end

  assign gap_full = (gap_cnt == GAP_MAX);

  // The frame is loaded on the edge entering PUBLISH so that frame_stb and
  // the new words appear together in the PUBLISH cycle.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dirty) begin
          if (gap_full) begin
            state_n = ST_PUBLISH;
            load    = 1'b1;
          end else begin
            state_n = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (gap_full) begin
          state_n = ST_PUBLISH;
          load    = 1'b1;
        end
      end
      ST_PUBLISH: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      power   <= 1'b0;
      mode    <= MODE_COOL;
      fan     <= FAN_RST;
      temp    <= TEMP_RST;
      seq     <= 4'd0;
      dirty   <= 1'b0;
      gap_cnt <= GAP_MAX;
      state   <= ST_IDLE;
      stb     <= 1'b0;
      ir35    <= build_data35(MODE_COOL, 1'b0, FAN_RST, TEMP_RST, TAIL35);
      ir32    <= build_data32(HEAD32, 4'd0,
                              frame_checksum(MODE_COOL, TEMP_RST, 1'b0, FAN_RST));
    end else begin
      power <= power_n;
      mode  <= mode_n;
      fan   <= fan_n;
      temp  <= temp_n;
      state <= state_n;
      stb   <= load;
      // A change landing on the load edge keeps dirty set for the next frame.
      dirty <= changed || (dirty && !load);
      if (load) begin
        gap_cnt <= '0;
      end else if (!gap_full) begin
        gap_cnt <= gap_cnt + GW'(1);
      end
      if (load) begin
        seq  <= seq + 4'd1;
        ir35 <= build_data35(mode, power, fan, temp, TAIL35);
        ir32 <= build_data32(HEAD32, seq + 4'd1,
                             frame_checksum(mode, temp, power, fan));
      end
    end
  end

  assign bus.ir_data35 = ir35;
  assign bus.ir_data32 = ir32;
  assign bus.frame_stb = stb;
  assign bus.power_on  = power;
  assign bus.temp_code = temp;

endmodule
